// File: rtl/full_subtractor.sv
// Registered WIDTH-bit full subtractor built as a ripple chain of 1-bit borrow cells.
// One-cycle latency, full throughput, with a synchronous active-high reset.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             out_valid
);

    // Walks the borrow through one cell per bit. A local variable carries the borrow,
    // so no vector ends up depending on its own bits.
    function automatic logic [WIDTH:0] ripple_sub(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             c
    );
        logic [WIDTH-1:0] d;
        logic             bw;
        d  = '0;
        bw = c;
        for (int i = 0; i < WIDTH; i++) begin
            d[i] = x[i] ^ y[i] ^ bw;
            bw   = (~x[i] & y[i]) | (~x[i] & bw) | (y[i] & bw);
        end
        return {bw, d};
    endfunction

    logic [WIDTH:0] result;

    always_comb begin
        result = ripple_sub(a, b, cin);
    end

    // Reset wins over a coincident operation; idle cycles keep the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff      <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff   <= result[WIDTH-1:0];
                borrow <= result[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8.
// Inputs are driven on the falling edge, and outputs are checked on a later falling edge.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, v1 = 1'b0;
    logic       diff1, borrow1, ov1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0, v8 = 1'b0;
    logic [7:0] diff8;
    logic       borrow8, ov8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .a(a1), .b(b1), .cin(cin1), .diff(diff1), .borrow(borrow1),
        .clk(clk), .rst(rst), .in_valid(v1), .out_valid(ov1)
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .a(a8), .b(b8), .cin(cin8), .diff(diff8), .borrow(borrow8),
        .clk(clk), .rst(rst), .in_valid(v8), .out_valid(ov8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic c, input logic v);
        a1 = a; b1 = b; cin1 = c; v1 = v;
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        a8 = a; b8 = b; cin8 = c; v8 = v;
    endtask

    initial begin
        logic [7:0] tt_diff;
        logic [7:0] tt_borrow;
        logic [7:0] bnd_a [4];
        logic [7:0] bnd_b [4];
        logic       bnd_c [4];
        logic [7:0] bnd_d [4];
        logic       bnd_bw[4];
        logic [8:0] exp_q;
        logic [8:0] ref_q;
        logic [2:0] vec;

        // Hand-computed truth table, bit i = row {a,b,cin} == i.
        tt_diff   = 8'b1001_0110;
        tt_borrow = 8'b1000_1110;

        bnd_a[0] = 8'h00; bnd_b[0] = 8'hFF; bnd_c[0] = 1'b1; bnd_d[0] = 8'h00; bnd_bw[0] = 1'b1;
        bnd_a[1] = 8'h50; bnd_b[1] = 8'h20; bnd_c[1] = 1'b1; bnd_d[1] = 8'h2F; bnd_bw[1] = 1'b0;
        bnd_a[2] = 8'hFF; bnd_b[2] = 8'h00; bnd_c[2] = 1'b0; bnd_d[2] = 8'hFF; bnd_bw[2] = 1'b0;
        bnd_a[3] = 8'h5A; bnd_b[3] = 8'h5A; bnd_c[3] = 1'b0; bnd_d[3] = 8'h00; bnd_bw[3] = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_diff1", diff1, 0);
        checkOutput("rst_borrow1", borrow1, 0);
        checkOutput("rst_ov1", ov1, 0);
        checkOutput("rst_diff8", diff8, 0);
        checkOutput("rst_borrow8", borrow8, 0);
        checkOutput("rst_ov8", ov8, 0);
        rst = 1'b0;

        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("tt_diff_%0d", i - 1), diff1, tt_diff[i-1]);
                checkOutput($sformatf("tt_borrow_%0d", i - 1), borrow1, tt_borrow[i-1]);
                checkOutput($sformatf("tt_ov_%0d", i - 1), ov1, 1);
            end
            if (i < 8) begin
                vec = 3'(i);
                applyStimulus1(vec[2], vec[1], vec[0], 1'b1);
            end else begin
                applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        checkOutput("tt_idle_ov", ov1, 0);
        checkOutput("tt_idle_diff", diff1, 1);
        checkOutput("tt_idle_borrow", borrow1, 1);

        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("bnd_diff_%0d", i - 1), diff8, bnd_d[i-1]);
                checkOutput($sformatf("bnd_borrow_%0d", i - 1), borrow8, bnd_bw[i-1]);
                checkOutput($sformatf("bnd_ov_%0d", i - 1), ov8, 1);
            end
            if (i < 4) applyStimulus8(bnd_a[i], bnd_b[i], bnd_c[i], 1'b1);
            else       applyStimulus8(8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Hold: one valid op, then garbage operands with in_valid low.
        @(negedge clk);
        applyStimulus8(8'h01, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("hold_diff_0", diff8, 8'h01);
        checkOutput("hold_borrow_0", borrow8, 0);
        checkOutput("hold_ov_0", ov8, 1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            @(negedge clk);
            checkOutput($sformatf("hold_diff_%0d", i), diff8, 8'h01);
            checkOutput($sformatf("hold_borrow_%0d", i), borrow8, 0);
            checkOutput($sformatf("hold_ov_%0d", i), ov8, 0);
        end

        // Reset coincident with valid operations discards them.
        applyStimulus1(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus8(8'h33, 8'h11, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstv_diff1", diff1, 0);
        checkOutput("rstv_borrow1", borrow1, 0);
        checkOutput("rstv_ov1", ov1, 0);
        checkOutput("rstv_diff8", diff8, 0);
        checkOutput("rstv_borrow8", borrow8, 0);
        checkOutput("rstv_ov8", ov8, 0);
        rst = 1'b0;
        applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus8(8'h10, 8'h01, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_diff8", diff8, 8'h0E);
        checkOutput("post_rst_borrow8", borrow8, 0);
        checkOutput("post_rst_ov8", ov8, 1);
        checkOutput("post_rst_ov1", ov1, 0);

        // Random back-to-back against a 9-bit reference subtraction.
        exp_q = '0;
        for (int k = 0; k <= 1000; k++) begin
            if (k > 0) begin
                @(negedge clk);
                checkOutput($sformatf("rnd_diff_%0d", k - 1), diff8, exp_q[7:0]);
                checkOutput($sformatf("rnd_borrow_%0d", k - 1), borrow8, exp_q[8]);
                checkOutput($sformatf("rnd_ov_%0d", k - 1), ov8, 1);
            end
            if (k < 1000) begin
                applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
                ref_q = {1'b0, a8} - {1'b0, b8} - {8'h00, cin8};
                exp_q = ref_q;
            end
        end
        applyStimulus8(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rnd_end_ov", ov8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
